// File: rtl/router_out_drain.sv
// Read-side drain controller for one router output FIFO: pulls header/payload/parity
// packets through a 2-entry skid buffer, checks parity and flushes on a stalled sink.
module router_out_drain #(
    parameter int TIMEOUT_CYCLES = 30,
    parameter int CNT_W          = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       fifo_soft_reset,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sop,
    output logic       out_eop,
    output logic       parity_err,
    output logic       timeout_err
);

    typedef enum logic [1:0] {HDR, LENW, PAY, PAR} state_t;

    state_t           state_q;
    logic [5:0]       rem_q;
    logic [7:0]       acc_q;
    logic             hold_q;
    logic             run_q;
    logic             rd_q;
    logic             tag_sop_q;
    logic             tag_eop_q;
    logic [9:0]       ent0_q;
    logic [9:0]       ent1_q;
    logic [1:0]       cnt_q;
    logic [CNT_W-1:0] stall_q;
    logic             flush_q;
    logic             flush2_q;
    logic             perr_q;

    logic       xfer;
    logic       credit_free;
    logic       timeout_hit;
    logic [9:0] new_ent;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = ent0_q[7:0];
    assign out_sop   = ent0_q[9] & out_valid;
    assign out_eop   = ent0_q[8] & out_valid;
    assign xfer      = out_valid & out_ready;

    // Entries plus the read in flight may never exceed 2; a transfer this cycle frees a slot.
    assign credit_free = (cnt_q == 2'd0) ||
                         ((cnt_q == 2'd1) && (!rd_q || xfer)) ||
                         ((cnt_q == 2'd2) && !rd_q && xfer);

    assign timeout_hit = out_valid & ~out_ready &
                         (stall_q == CNT_W'(TIMEOUT_CYCLES - 1));

    assign fifo_rd = run_q & ~fifo_empty & credit_free & ~hold_q & ~flush_q & ~flush2_q;

    assign new_ent         = {tag_sop_q, tag_eop_q, fifo_data};
    assign fifo_soft_reset = flush_q;
    assign timeout_err     = flush_q;
    assign parity_err      = perr_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= HDR;
            rem_q     <= '0;
            acc_q     <= '0;
            hold_q    <= 1'b0;
            run_q     <= 1'b0;
            rd_q      <= 1'b0;
            tag_sop_q <= 1'b0;
            tag_eop_q <= 1'b0;
            ent0_q    <= '0;
            ent1_q    <= '0;
            cnt_q     <= '0;
            stall_q   <= '0;
            flush_q   <= 1'b0;
            flush2_q  <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            flush2_q <= flush_q;
            perr_q   <= 1'b0;
            if (timeout_hit) begin
                // Drop everything buffered or in flight and restart framing at a header.
                flush_q   <= 1'b1;
                state_q   <= HDR;
                rem_q     <= '0;
                acc_q     <= '0;
                hold_q    <= 1'b0;
                rd_q      <= 1'b0;
                tag_sop_q <= 1'b0;
                tag_eop_q <= 1'b0;
                ent0_q    <= '0;
                ent1_q    <= '0;
                cnt_q     <= '0;
                stall_q   <= '0;
            end else begin
                flush_q   <= 1'b0;
                rd_q      <= fifo_rd;
                tag_sop_q <= fifo_rd & (state_q == HDR);
                tag_eop_q <= fifo_rd & (state_q == PAR);

                if (!out_valid || xfer) stall_q <= '0;
                else                    stall_q <= stall_q + CNT_W'(1);

                case ({rd_q, xfer})
                    2'b10: begin
                        if (cnt_q == 2'd0) ent0_q <= new_ent;
                        else               ent1_q <= new_ent;
                        cnt_q <= cnt_q + 2'd1;
                    end
                    2'b01: begin
                        ent0_q <= ent1_q;
                        cnt_q  <= cnt_q - 2'd1;
                    end
                    2'b11: begin
                        if (cnt_q == 2'd1) begin
                            ent0_q <= new_ent;
                        end else begin
                            ent0_q <= ent1_q;
                            ent1_q <= new_ent;
                        end
                    end
                    default: ;
                endcase

                if (rd_q) begin
                    if (tag_sop_q)      acc_q  <= fifo_data;
                    else if (tag_eop_q) perr_q <= (acc_q != fifo_data);
                    else                acc_q  <= acc_q ^ fifo_data;
                end

                case (state_q)
                    HDR: if (fifo_rd) begin
                        state_q <= LENW;
                        hold_q  <= 1'b1;
                    end
                    LENW: if (rd_q) begin
                        hold_q  <= 1'b0;
                        rem_q   <= fifo_data[7:2];
                        state_q <= (fifo_data[7:2] != 6'd0) ? PAY : PAR;
                    end
                    PAY: if (fifo_rd) begin
                        rem_q <= rem_q - 6'd1;
                        if (rem_q == 6'd1) state_q <= PAR;
                    end
                    PAR: if (fifo_rd) state_q <= HDR;
                    default: state_q <= HDR;
                endcase
            end
        end
    end

endmodule
